// File: rtl/access_menu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : access_menu_ctrl
// Brief    : Session-flow controller selecting the LCD message code, gating
//            ID/password entry, lockout after repeated failures, game start.
// Revision : 1.0 - initial release
// ============================================================================
module access_menu_ctrl #(
  parameter int SPLASH_CYCLES = 24000000,
  parameter int SCORE_CYCLES  = 120000000,
  parameter int LOCK_CYCLES   = 240000000,
  parameter int MAX_TRIES     = 3,
  parameter int TW            = 28
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_LOGIN,
  input  logic       BTN_QUIT,
  input  logic       BTN_PLAY,
  input  logic       BTN_SCORES,
  input  logic       ID_OK,
  input  logic       ID_BAD,
  input  logic       PW_OK,
  input  logic       PW_BAD,
  input  logic       GAME_DONE,
  output logic [3:0] LCD_CHAR_ARRAY,
  output logic       ID_REQ,
  output logic       PW_REQ,
  output logic       GAME_START,
  output logic       LOCKED
);

  localparam int TRW = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);

  // State encodings double as the LCD message-select codes.
  localparam logic [3:0] c_ST_SPLASH  = 4'hF;
  localparam logic [3:0] c_ST_WELCOME = 4'h0;
  localparam logic [3:0] c_ST_IDEN    = 4'h1;
  localparam logic [3:0] c_ST_PWRD    = 4'h2;
  localparam logic [3:0] c_ST_OPTIONS = 4'h3;
  localparam logic [3:0] c_ST_GAME    = 4'h4;
  localparam logic [3:0] c_ST_SCORES  = 4'h5;
  localparam logic [3:0] c_ST_LOCKOUT = 4'h6;

  localparam logic [TW-1:0]  c_SPLASH_LAST = TW'(SPLASH_CYCLES - 1);
  localparam logic [TW-1:0]  c_SCORE_LAST  = TW'(SCORE_CYCLES - 1);
  localparam logic [TW-1:0]  c_LOCK_LAST   = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0]  c_TIMER_ONE   = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TRW-1:0] c_TRIES_SAT   = {TRW{1'b1}};
  localparam logic [TRW:0]   c_TRIES_LIMIT = (TRW+1)'(MAX_TRIES);

  logic [3:0]     r_state;
  logic [TW-1:0]  r_timer;
  logic [TRW-1:0] r_tries;

  logic [3:0]     w_state_nxt;
  logic [TW-1:0]  w_timer_nxt;
  logic [TRW-1:0] w_tries_nxt;
  logic [TRW:0]   w_tries_inc;
  logic           w_timeout;
  logic           w_timed_state;
  logic           w_fail;

  always_comb begin
    w_timeout     = 1'b0;
    w_timed_state = 1'b0;
    case (r_state)
      c_ST_SPLASH: begin
        w_timed_state = 1'b1;
        w_timeout     = (r_timer == c_SPLASH_LAST);
      end
      c_ST_SCORES: begin
        w_timed_state = 1'b1;
        w_timeout     = (r_timer == c_SCORE_LAST);
      end
      c_ST_LOCKOUT: begin
        w_timed_state = 1'b1;
        w_timeout     = (r_timer == c_LOCK_LAST);
      end
      default: begin
        w_timed_state = 1'b0;
        w_timeout     = 1'b0;
      end
    endcase
  end

  assign w_tries_inc = {1'b0, r_tries} + {{TRW{1'b0}}, 1'b1};

  always_comb begin
    w_state_nxt = r_state;
    w_tries_nxt = r_tries;
    w_fail      = 1'b0;
    case (r_state)
      c_ST_SPLASH: begin
        if (w_timeout) w_state_nxt = c_ST_WELCOME;
      end
      c_ST_WELCOME: begin
        if (BTN_QUIT)       w_state_nxt = c_ST_SPLASH;
        else if (BTN_LOGIN) w_state_nxt = c_ST_IDEN;
      end
      c_ST_IDEN: begin
        if (BTN_QUIT)     w_state_nxt = c_ST_WELCOME;
        else if (ID_BAD)  w_fail      = 1'b1;
        else if (ID_OK)   w_state_nxt = c_ST_PWRD;
      end
      c_ST_PWRD: begin
        if (BTN_QUIT)     w_state_nxt = c_ST_WELCOME;
        else if (PW_BAD)  w_fail      = 1'b1;
        else if (PW_OK) begin
          w_state_nxt = c_ST_OPTIONS;
          w_tries_nxt = '0;
        end
      end
      c_ST_OPTIONS: begin
        if (BTN_QUIT)        w_state_nxt = c_ST_WELCOME;
        else if (BTN_PLAY)   w_state_nxt = c_ST_GAME;
        else if (BTN_SCORES) w_state_nxt = c_ST_SCORES;
      end
      c_ST_GAME: begin
        if (GAME_DONE) w_state_nxt = c_ST_SCORES;
      end
      c_ST_SCORES: begin
        if (BTN_QUIT || w_timeout) w_state_nxt = c_ST_OPTIONS;
      end
      c_ST_LOCKOUT: begin
        if (w_timeout) w_state_nxt = c_ST_WELCOME;
      end
      default: begin
        w_state_nxt = c_ST_SPLASH;
      end
    endcase

    // A failure either trips the lockout or bumps the saturating counter.
    if (w_fail) begin
      if (w_tries_inc == c_TRIES_LIMIT) begin
        w_state_nxt = c_ST_LOCKOUT;
        w_tries_nxt = '0;
      end else if (r_tries != c_TRIES_SAT) begin
        w_tries_nxt = w_tries_inc[TRW-1:0];
      end
    end

    if (w_state_nxt == c_ST_WELCOME) w_tries_nxt = '0;
  end

  always_comb begin
    if (w_state_nxt != r_state) w_timer_nxt = '0;
    else if (w_timed_state)     w_timer_nxt = r_timer + c_TIMER_ONE;
    else                        w_timer_nxt = '0;
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state        <= c_ST_SPLASH;
      r_timer        <= '0;
      r_tries        <= '0;
      LCD_CHAR_ARRAY <= c_ST_SPLASH;
      ID_REQ         <= 1'b0;
      PW_REQ         <= 1'b0;
      GAME_START     <= 1'b0;
      LOCKED         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_timer        <= w_timer_nxt;
      r_tries        <= w_tries_nxt;
      LCD_CHAR_ARRAY <= w_state_nxt;
      ID_REQ         <= (w_state_nxt == c_ST_IDEN);
      PW_REQ         <= (w_state_nxt == c_ST_PWRD);
      GAME_START     <= (w_state_nxt == c_ST_GAME) && (r_state == c_ST_OPTIONS);
      LOCKED         <= (w_state_nxt == c_ST_LOCKOUT);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_access_menu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_access_menu_ctrl
// Brief    : Directed scoreboard bench for access_menu_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_access_menu_ctrl;

  localparam int SPL = 10;
  localparam int SCR = 8;
  localparam int LCK = 20;

  localparam logic [8:0] M_LOGIN  = 9'h001;
  localparam logic [8:0] M_QUIT   = 9'h002;
  localparam logic [8:0] M_PLAY   = 9'h004;
  localparam logic [8:0] M_SCORES = 9'h008;
  localparam logic [8:0] M_IDOK   = 9'h010;
  localparam logic [8:0] M_IDBAD  = 9'h020;
  localparam logic [8:0] M_PWOK   = 9'h040;
  localparam logic [8:0] M_PWBAD  = 9'h080;
  localparam logic [8:0] M_DONE   = 9'h100;
  localparam logic [8:0] M_NONE   = 9'h000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [8:0] btn = '0;
  logic       BTN_LOGIN, BTN_QUIT, BTN_PLAY, BTN_SCORES;
  logic       ID_OK, ID_BAD, PW_OK, PW_BAD, GAME_DONE;
  logic [3:0] LCD_CHAR_ARRAY;
  logic       ID_REQ, PW_REQ, GAME_START, LOCKED;

  assign {GAME_DONE, PW_BAD, PW_OK, ID_BAD, ID_OK,
          BTN_SCORES, BTN_PLAY, BTN_QUIT, BTN_LOGIN} = btn;

  access_menu_ctrl #(
    .SPLASH_CYCLES(SPL), .SCORE_CYCLES(SCR), .LOCK_CYCLES(LCK),
    .MAX_TRIES(3), .TW(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .BTN_LOGIN(BTN_LOGIN), .BTN_QUIT(BTN_QUIT), .BTN_PLAY(BTN_PLAY),
    .BTN_SCORES(BTN_SCORES), .ID_OK(ID_OK), .ID_BAD(ID_BAD),
    .PW_OK(PW_OK), .PW_BAD(PW_BAD), .GAME_DONE(GAME_DONE),
    .LCD_CHAR_ARRAY(LCD_CHAR_ARRAY), .ID_REQ(ID_REQ), .PW_REQ(PW_REQ),
    .GAME_START(GAME_START), .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  string      tag_q[$];
  logic [4:0] exp_q[$];

  task automatic cmp(input string tag, input string fld,
                     input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] code, input logic gs);
    tag_q.push_back(tag);
    exp_q.push_back({gs, code});
  endtask

  // Flags are derived from the expected code: each request line tracks one screen.
  task automatic check_out();
    string      tag;
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      cmp(tag, "code",  LCD_CHAR_ARRAY, e[3:0]);
      cmp(tag, "idreq", {3'b0, ID_REQ},     {3'b0, e[3:0] == 4'h1});
      cmp(tag, "pwreq", {3'b0, PW_REQ},     {3'b0, e[3:0] == 4'h2});
      cmp(tag, "lock",  {3'b0, LOCKED},     {3'b0, e[3:0] == 4'h6});
      cmp(tag, "gs",    {3'b0, GAME_START}, {3'b0, e[4]});
    end
  endtask

  // Called at a falling edge: the pulse is sampled on the next rising edge.
  task automatic step(input string tag, input logic [8:0] mask,
                      input logic [3:0] code, input logic gs);
    expect_out(tag, code, gs);
    btn = mask;
    @(negedge CLK);
    btn = M_NONE;
    check_out();
  endtask

  task automatic splash_run(input string tag);
    for (int i = 1; i <= SPL; i++)
      step(tag, M_NONE, (i == SPL) ? 4'h0 : 4'hF, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    expect_out("rst", 4'hF, 1'b0);
    check_out();
    @(negedge CLK);
    RST = 1'b0;

    splash_run("splash");
    step("login",  M_LOGIN, 4'h1, 1'b0);
    step("stray",  M_PWOK,  4'h1, 1'b0);
    step("idok",   M_IDOK,  4'h2, 1'b0);
    step("pwok",   M_PWOK,  4'h3, 1'b0);

    step("play",      M_PLAY | M_SCORES, 4'h4, 1'b1);
    step("gs_width",  M_NONE,            4'h4, 1'b0);
    step("quit_game", M_QUIT,            4'h4, 1'b0);
    step("done",      M_DONE,            4'h5, 1'b0);
    for (int i = 1; i <= SCR; i++)
      step("scr_to", M_NONE, (i == SCR) ? 4'h3 : 4'h5, 1'b0);

    step("scores", M_SCORES, 4'h5, 1'b0);
    for (int i = 1; i < SCR; i++)
      step("scr_wait", M_NONE, 4'h5, 1'b0);
    step("quit_to",  M_QUIT, 4'h3, 1'b0);
    step("after_to", M_NONE, 4'h3, 1'b0);

    step("quit_opt", M_QUIT,  4'h0, 1'b0);
    step("login2",   M_LOGIN, 4'h1, 1'b0);
    step("stray2",   M_PWOK,  4'h1, 1'b0);
    step("idbad",    M_IDBAD, 4'h1, 1'b0);
    step("idok2",    M_IDOK,  4'h2, 1'b0);
    step("pwbad",    M_PWBAD, 4'h2, 1'b0);
    step("pwbad2",   M_PWBAD, 4'h6, 1'b0);
    for (int i = 1; i <= LCK; i++)
      step("lock", (i == 5) ? (M_LOGIN | M_QUIT | M_IDBAD) : M_NONE,
           (i == LCK) ? 4'h0 : 4'h6, 1'b0);

    step("login3",  M_LOGIN,          4'h1, 1'b0);
    step("idbad_a", M_IDBAD,          4'h1, 1'b0);
    step("idboth",  M_IDOK | M_IDBAD, 4'h1, 1'b0);
    step("idbad_c", M_IDBAD,          4'h6, 1'b0);
    for (int i = 0; i < 3; i++)
      step("lock2", M_NONE, 4'h6, 1'b0);

    #2 RST = 1'b1;
    #1 expect_out("arst_lock", 4'hF, 1'b0);
    check_out();
    @(negedge CLK);
    expect_out("arst_hold", 4'hF, 1'b0);
    check_out();
    RST = 1'b0;
    splash_run("splash2");

    step("wquit", M_QUIT, 4'hF, 1'b0);
    splash_run("splash3");

    step("login4",  M_LOGIN,         4'h1, 1'b0);
    step("idokq",   M_IDOK | M_QUIT, 4'h0, 1'b0);
    step("login5",  M_LOGIN,         4'h1, 1'b0);
    step("idok5",   M_IDOK,          4'h2, 1'b0);
    step("pwok5",   M_PWOK,          4'h3, 1'b0);
    step("play5",   M_PLAY,          4'h4, 1'b1);
    step("game5",   M_NONE,          4'h4, 1'b0);

    #2 RST = 1'b1;
    #1 expect_out("arst_game", 4'hF, 1'b0);
    check_out();
    @(negedge CLK);
    expect_out("arst_ghold", 4'hF, 1'b0);
    check_out();
    RST = 1'b0;
    step("post_rst", M_PLAY, 4'hF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
